mem_access_ctrl: RTL

Initiator-side controller for the byte-addressed `ram512x8`-style memory port. It sits between the CPU control unit and the RAM. It accepts one sized read or write request at a time, drives the RAM strobes (Enable, ReadWrite, Address, DataIn, OpCode), and waits for MOC. A doubleword is split into two word transactions, and read data is returned as a zero- or sign-extended 64-bit result. Misaligned requests and RAM timeouts are reported as error responses.

---
 rtl/mem_access_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a byte-addressed RAM port: sized single requests,
// doublewords split into two word beats, extended read results, and error responses.
module mem_access_ctrl #(
   parameter int ADDR_W  = 7,
   parameter int TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic [1:0]        ReqSize,
   input  logic              ReqSigned,
   input  logic [ADDR_W-1:0] ReqAddr,
   input  logic [63:0]       ReqWData,
   output logic              RspValid,
   output logic [63:0]       RspRData,
   output logic              RspError,
   output logic              MemEnable,
   output logic              MemReadWrite,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [31:0]       MemDataIn,
   output logic [1:0]        MemOpCode,
   input  logic [31:0]       MemDataOut,
   input  logic              MemMOC
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_DW   = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      GAP,
      RESP
   } state_t;

   state_t              state_q, state_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [63:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_error_q, rsp_error_d;
   logic                mem_enable_q, mem_enable_d;
   logic                mem_read_write_q, mem_read_write_d;
   logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
   logic [31:0]         mem_data_in_q, mem_data_in_d;
   logic [1:0]          mem_op_code_q, mem_op_code_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          size_q, size_d;
   logic                signed_q, signed_d;
   logic                write_q, write_d;
   logic [31:0]         wdata_lo_q, wdata_lo_d;
   logic [31:0]         beat0_q, beat0_d;
   logic                second_q, second_d;
   logic                misaligned;

   function automatic logic [63:0] extend_read(input logic [1:0] size,
                                               input logic sgn,
                                               input logic [31:0] d);
      logic [63:0] r;
      case (size)
         SIZE_BYTE: r = sgn ? {{56{d[7]}}, d[7:0]}   : {56'h0, d[7:0]};
         SIZE_HALF: r = sgn ? {{48{d[15]}}, d[15:0]} : {48'h0, d[15:0]};
         default:   r = sgn ? {{32{d[31]}}, d}       : {32'h0, d};
      endcase
      return r;
   endfunction

   // First (or only) beat of write data, right-justified into the RAM data bus.
   function automatic logic [31:0] first_beat(input logic [1:0] size,
                                              input logic [63:0] wdata);
      logic [31:0] r;
      case (size)
         SIZE_BYTE: r = {24'h0, wdata[7:0]};
         SIZE_HALF: r = {16'h0, wdata[15:0]};
         SIZE_WORD: r = wdata[31:0];
         default:   r = wdata[63:32];
      endcase
      return r;
   endfunction

   always_comb begin
      case (ReqSize)
         SIZE_HALF: misaligned = ReqAddr[0];
         SIZE_WORD: misaligned = |ReqAddr[1:0];
         SIZE_DW:   misaligned = |ReqAddr[2:0];
         default:   misaligned = 1'b0;
      endcase
   end

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_d          = state_q;
      req_ready_d      = req_ready_q;
      rsp_valid_d      = 1'b0;
      rsp_rdata_d      = rsp_rdata_q;
      rsp_error_d      = rsp_error_q;
      mem_enable_d     = mem_enable_q;
      mem_read_write_d = mem_read_write_q;
      mem_address_d    = mem_address_q;
      mem_data_in_d    = mem_data_in_q;
      mem_op_code_d    = mem_op_code_q;
      cnt_d            = cnt_q;
      size_d           = size_q;
      signed_d         = signed_q;
      write_d          = write_q;
      wdata_lo_d       = wdata_lo_q;
      beat0_d          = beat0_q;
      second_d         = second_q;

      case (state_q)
         IDLE: begin
            if (ReqValid && req_ready_q) begin
               req_ready_d = 1'b0;
               size_d      = ReqSize;
               signed_d    = ReqSigned;
               write_d     = ReqWrite;
               wdata_lo_d  = ReqWData[31:0];
               second_d    = 1'b0;
               if (misaligned) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
                  rsp_rdata_d = 64'h0;
               end else begin
                  state_d          = ACCESS;
                  mem_enable_d     = 1'b1;
                  mem_read_write_d = ~ReqWrite;
                  mem_address_d    = ReqAddr;
                  mem_op_code_d    = (ReqSize == SIZE_DW) ? SIZE_WORD : ReqSize;
                  mem_data_in_d    = first_beat(ReqSize, ReqWData);
                  cnt_d            = '0;
               end
            end
         end

         ACCESS: begin
            if (MemMOC) begin
               mem_enable_d = 1'b0;
               if (size_q == SIZE_DW && !second_q) begin
                  state_d       = GAP;
                  beat0_d       = MemDataOut;
                  mem_address_d = mem_address_q + ADDR_W'(4);
                  mem_data_in_d = wdata_lo_q;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b0;
                  if (write_q)
                     rsp_rdata_d = 64'h0;
                  else if (size_q == SIZE_DW)
                     rsp_rdata_d = {beat0_q, MemDataOut};
                  else
                     rsp_rdata_d = extend_read(size_q, signed_q, MemDataOut);
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d      = RESP;
               mem_enable_d = 1'b0;
               rsp_valid_d  = 1'b1;
               rsp_error_d  = 1'b1;
               rsp_rdata_d  = 64'h0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         GAP: begin
            state_d      = ACCESS;
            mem_enable_d = 1'b1;
            cnt_d        = '0;
            second_d     = 1'b1;
         end

         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q          <= IDLE;
         req_ready_q      <= 1'b1;
         rsp_valid_q      <= 1'b0;
         rsp_rdata_q      <= 64'h0;
         rsp_error_q      <= 1'b0;
         mem_enable_q     <= 1'b0;
         mem_read_write_q <= 1'b1;
         mem_address_q    <= '0;
         mem_data_in_q    <= 32'h0;
         mem_op_code_q    <= 2'b00;
         cnt_q            <= '0;
         size_q           <= 2'b00;
         signed_q         <= 1'b0;
         write_q          <= 1'b0;
         wdata_lo_q       <= 32'h0;
         beat0_q          <= 32'h0;
         second_q         <= 1'b0;
      end else begin
         state_q          <= state_d;
         req_ready_q      <= req_ready_d;
         rsp_valid_q      <= rsp_valid_d;
         rsp_rdata_q      <= rsp_rdata_d;
         rsp_error_q      <= rsp_error_d;
         mem_enable_q     <= mem_enable_d;
         mem_read_write_q <= mem_read_write_d;
         mem_address_q    <= mem_address_d;
         mem_data_in_q    <= mem_data_in_d;
         mem_op_code_q    <= mem_op_code_d;
         cnt_q            <= cnt_d;
         size_q           <= size_d;
         signed_q         <= signed_d;
         write_q          <= write_d;
         wdata_lo_q       <= wdata_lo_d;
         beat0_q          <= beat0_d;
         second_q         <= second_d;
      end
   end

   assign ReqReady     = req_ready_q;
   assign RspValid     = rsp_valid_q;
   assign RspRData     = rsp_rdata_q;
   assign RspError     = rsp_error_q;
   assign MemEnable    = mem_enable_q;
   assign MemReadWrite = mem_read_write_q;
   assign MemAddress   = mem_address_q;
   assign MemDataIn    = mem_data_in_q;
   assign MemOpCode    = mem_op_code_q;

endmodule
